vdg_text_shifter: RTL

VDG_TEXT_SHIFTER -- requirements
Module: vdg_text_shifter

---
 rtl/vdg_text_shifter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/vdg_text_shifter.sv
// vdg_text_shifter: 6847-style character fetch, pattern staging and 8-pixel shifter
module vdg_text_shifter #(
    parameter int FIRST_ROW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       char_valid,
    input  logic [7:0] char_code,
    input  logic [3:0] char_row,
    output logic       char_ready,
    output logic [9:0] rom_addr,
    output logic       rom_cs,
    input  logic [7:0] rom_dout,
    output logic       pix_valid,
    output logic       pix_fg,
    output logic       pix_sg,
    output logic [2:0] pix_color,
    output logic       underrun
);
    typedef enum logic [1:0] {IDLE, FETCH, CAPT} state_t;
    state_t     state, state_nx;
    logic [7:0] hold_code;
    logic [3:0] hold_row;
    logic       hold_full;
    logic [7:0] stage;
    logic       stage_sg;
    logic [2:0] stage_color;
    logic       stage_full;
    logic [7:0] shifter;
    logic       shift_sg;
    logic [2:0] shift_color;
    logic [2:0] cnt;
    logic       sg, inv, row_ok, quad_l, quad_r;
    logic [2:0] font_row;
    logic [7:0] pattern;

    assign char_ready = !hold_full;
    assign sg         = hold_code[7];
    assign inv        = hold_code[6];
    assign font_row   = 3'(hold_row - 4'(FIRST_ROW));
    assign row_ok     = hold_row >= 4'(FIRST_ROW) && hold_row <= 4'(FIRST_ROW + 7);
    assign quad_l     = hold_row < 4'd6 ? hold_code[3] : hold_code[1];
    assign quad_r     = hold_row < 4'd6 ? hold_code[2] : hold_code[0];
    assign pattern    = sg ? (hold_row < 4'd12 ? {{4{quad_l}}, {4{quad_r}}} : 8'h00)
                           : (row_ok ? rom_dout : 8'h00) ^ {8{inv}};

    // fetch sequencing and the ROM strobe, which is only raised for in-range text rows
    always_comb begin
        state_nx = state == IDLE ? (hold_full && !stage_full ? FETCH : IDLE) : state == FETCH ? CAPT : IDLE;
        rom_cs   = state == FETCH && !sg && row_ok;
        rom_addr = rom_cs ? {1'b0, hold_code[5:0], font_row} : 10'd0;
    end

    // fetch state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_nx;

    // holding register: filled by a handshake, emptied when its pattern is captured
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            hold_full <= 1'b0;
            hold_code <= 8'd0;
            hold_row  <= 4'd0;
        end else if (char_valid && char_ready) begin
            hold_full <= 1'b1;
            hold_code <= char_code;
            hold_row  <= char_row;
        end else if (state == CAPT) begin
            hold_full <= 1'b0;
        end

    // stage register: capture never meets a load since fetches only start with the stage empty
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            stage       <= 8'd0;
            stage_sg    <= 1'b0;
            stage_color <= 3'd0;
            stage_full  <= 1'b0;
        end else begin
            if (state == CAPT) begin
                stage       <= pattern;
                stage_sg    <= sg;
                stage_color <= sg ? hold_code[6:4] : 3'd0;
            end
            stage_full <= state == CAPT || (stage_full && !(pix_ce && cnt == 3'd0));
        end

    // pixel shifter; underrun flags a break in a running pixel stream, not idle before the first character
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            shifter     <= 8'd0;
            shift_sg    <= 1'b0;
            shift_color <= 3'd0;
            cnt         <= 3'd0;
            pix_valid   <= 1'b0;
            pix_fg      <= 1'b0;
            pix_sg      <= 1'b0;
            pix_color   <= 3'd0;
            underrun    <= 1'b0;
        end else if (pix_ce) begin
            if (cnt != 3'd0) begin
                pix_valid <= 1'b1;
                pix_fg    <= shifter[7];
                pix_sg    <= shift_sg;
                pix_color <= shift_color;
                shifter   <= {shifter[6:0], 1'b0};
                cnt       <= cnt - 3'd1;
            end else if (stage_full) begin
                pix_valid   <= 1'b1;
                pix_fg      <= stage[7];
                pix_sg      <= stage_sg;
                pix_color   <= stage_color;
                shifter     <= {stage[6:0], 1'b0};
                shift_sg    <= stage_sg;
                shift_color <= stage_color;
                cnt         <= 3'd7;
            end else begin
                pix_valid <= 1'b0;
                pix_fg    <= 1'b0;
                pix_sg    <= 1'b0;
                pix_color <= 3'd0;
                underrun  <= underrun | pix_valid;
            end
        end
endmodule
